uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Frame sequencer for the UART receive path. It detects the start edge on the oversampled serial line and runs the per-bit edge and bit counters. It issues one-cycle enables to the data sampler, start checker, deserializer, parity checker and stop checker. At the end of each frame it reports either a valid byte or a frame error to the downstream synchronizer.

## Interface
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_W, 6, width of prescale and edge counter
- clk  in  1  receive-domain clock (oversampling clock)
- reset_n  in  1  asynchronous, active-low reset
- rx_in  in  1  serial line, already synchronized to clk, idle high
- par_en_in  in  1  1 = frame carries a parity bit
- prescale_in  in  PRESCALE_W  oversampling ratio, cycles per bit; even, 8..32
- strt_glitch_in  in  1  start checker result; valid while strt_chk_en_out=1
- par_err_in  in  1  parity checker result; valid while par_chk_en_out=1
- stp_err_in  in  1  stop checker result; valid while stp_chk_en_out=1
- edge_cnt_out  out  PRESCALE_W  cycle index within current bit
- bit_cnt_out  out  4  bit index within frame (0 = start bit)
- dat_samp_en_out  out  1  sampler enable
- strt_chk_en_out  out  1  start-check strobe
- deser_en_out  out  1  deserializer shift strobe
- par_chk_en_out  out  1  parity-check strobe
- stp_chk_en_out  out  1  stop-check strobe
- data_valid_out  out  1  one-cycle pulse: frame received without error
- frame_err_out  out  1  one-cycle pulse: parity or stop error in frame

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. Encoding is free.
- Latching at start detection: par_en_in and prescale_in are latched in IDLE on the start-detect cycle. Later changes have no effect on the frame in progress. Prescale values below 8 are treated as 8. Odd values are rounded down.
- P denotes the latched prescale. CHK = P/2+2 is the first cycle on which the sampler's majority result is stable.
- Counters: edge_cnt and bit_cnt are held at 0 in IDLE and DONE. In other states edge_cnt increments every cycle. When edge_cnt = P-1, edge_cnt wraps to 0 and bit_cnt increments.
- IDLE: rx_in=0 moves the FSM to START. START is entered with edge_cnt=0 and bit_cnt=0.
- START: strt_chk_en_out=1 at edge CHK.
  - strt_glitch_in=1 on that cycle moves the FSM to IDLE, with counters cleared and no output pulse.
  - Otherwise, edge P-1 moves the FSM to DATA.
- DATA: deser_en_out=1 at edge CHK of each data bit. At edge P-1 with bit_cnt=DATA_WIDTH, the FSM moves to PARITY if latched par_en=1, else to STOP.
- PARITY: par_chk_en_out=1 at edge CHK, and par_err_in is latched into an internal flag. Edge P-1 moves the FSM to STOP.
- STOP: stp_chk_en_out=1 at edge CHK, and stp_err_in is latched. The next cycle the FSM moves to DONE. It leaves early, mid stop bit, to allow back-to-back frames.
- DONE: lasts exactly one cycle.
  - Both error flags 0 gives data_valid_out=1; otherwise frame_err_out=1.
  - Both error flags clear on exit.
  - Next state is START if rx_in=0, else IDLE.
- dat_samp_en_out=1 in START, DATA, PARITY and STOP. It is 0 in IDLE and DONE.
- data_valid_out and frame_err_out are never both 1.

## Timing
- All outputs decode from registered state, counters and flags. There is no combinational path from any input to any output.
- Reset: while reset_n=0, state=IDLE and every output is 0, including both counters. Reset mid-frame aborts the frame with no pulse.
- Start detected on cycle 0 (IDLE, rx_in=0):
  - START is entered at cycle 1.
  - Data bit b spans cycles 1+P(b+1) .. P(b+2).
  - The stop-check strobe falls on cycle 1+P(DATA_WIDTH+1+par_en)+CHK.
  - DONE, and the result pulse, come 1 cycle after the stop-check strobe.
- Each strobe is exactly 1 cycle wide per bit.
- Back-to-back frames: rx_in=0 during DONE starts the next frame with no IDLE cycle.

## Test plan
- Clean 8N1 frame, P=8, byte 0xA5: start detected at cycle 0.
  - deser_en_out pulses at cycles 15, 23, …, 71.
  - stp_chk_en_out pulses at 79.
  - data_valid_out=1 at 80 only, and frame_err_out stays 0.
- Even-parity frame, P=8, par_en_in=1, par_err_in=1 at par_chk strobe (cycle 79): stp_chk at 87; frame_err_out=1 at cycle 88; data_valid_out stays 0.
- Start glitch: rx_in low for 2 cycles, strt_glitch_in=1 at cycle 7 (edge CHK=6).
  - FSM is back in IDLE at cycle 8, with counters 0.
  - No strobes other than strt_chk_en_out, and no result pulse.
- Stop error, P=16: stp_err_in=1 at the stop strobe; frame_err_out pulses once, 1 cycle later.
  - Then change prescale_in mid-frame: the edge count still wraps at 15.
- Back-to-back frames with rx_in=0 in DONE: START is entered the next cycle, and the second data_valid_out comes exactly 80 cycles after the first (P=8, 8N1).
- Assert reset_n=0 during the DATA state at bit_cnt=4: all outputs are 0 immediately.
  - After release, an 8N1 frame is received normally.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer: start detect, edge/bit counters, checker strobes
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_in,
    input  logic                  par_en_in,
    input  logic [PRESCALE_W-1:0] prescale_in,
    input  logic                  strt_glitch_in,
    input  logic                  par_err_in,
    input  logic                  stp_err_in,
    output logic [PRESCALE_W-1:0] edge_cnt_out,
    output logic [3:0]            bit_cnt_out,
    output logic                  dat_samp_en_out,
    output logic                  strt_chk_en_out,
    output logic                  deser_en_out,
    output logic                  par_chk_en_out,
    output logic                  stp_chk_en_out,
    output logic                  data_valid_out,
    output logic                  frame_err_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] last_q, chk_q;
    logic                  par_en_q;
    logic                  par_err_q, stp_err_q;
    logic                  latch_cfg;

    // Effective prescale: forced even, floored at 8.
    logic [PRESCALE_W-1:0] p_even, p_eff;
    assign p_even = prescale_in & ~PRESCALE_W'(1);
    assign p_eff  = (p_even < PRESCALE_W'(8)) ? PRESCALE_W'(8) : p_even;

    logic at_chk, at_last;
    assign at_chk  = (edge_q == chk_q);
    assign at_last = (edge_q == last_q);

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        latch_cfg = 1'b0;
        if (at_last) begin
            edge_d = '0;
            bit_d  = bit_q + 4'd1;
        end else begin
            edge_d = edge_q + PRESCALE_W'(1);
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                edge_d  = '0;
                bit_d   = '0;
                state_d = S_IDLE;
                if (!rx_in) begin
                    state_d   = S_START;
                    latch_cfg = 1'b1;
                end
            end
            S_START: begin
                if (at_chk && strt_glitch_in) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (at_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_last && (bit_q == 4'(DATA_WIDTH)))
                    state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_last)
                    state_d = S_STOP;
            end
            S_STOP: begin
                // Leave mid stop bit so a following start edge is not missed.
                if (at_chk) begin
                    state_d = S_DONE;
                    edge_d  = '0;
                    bit_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            last_q    <= PRESCALE_W'(7);
            chk_q     <= PRESCALE_W'(6);
            par_en_q  <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            if (latch_cfg) begin
                last_q   <= p_eff - PRESCALE_W'(1);
                chk_q    <= (p_eff >> 1) + PRESCALE_W'(2);
                par_en_q <= par_en_in;
            end
            if (state_q == S_DONE) begin
                par_err_q <= 1'b0;
                stp_err_q <= 1'b0;
            end else begin
                if (par_chk_en_out)
                    par_err_q <= par_err_in;
                if (stp_chk_en_out)
                    stp_err_q <= stp_err_in;
            end
        end
    end

    assign edge_cnt_out    = edge_q;
    assign bit_cnt_out     = bit_q;
    assign dat_samp_en_out = (state_q == S_START) || (state_q == S_DATA) ||
                             (state_q == S_PARITY) || (state_q == S_STOP);
    assign strt_chk_en_out = (state_q == S_START) && at_chk;
    assign deser_en_out    = (state_q == S_DATA) && at_chk;
    assign par_chk_en_out  = (state_q == S_PARITY) && at_chk;
    assign stp_chk_en_out  = (state_q == S_STOP) && at_chk;
    assign data_valid_out  = (state_q == S_DONE) && !(par_err_q || stp_err_q);
    assign frame_err_out   = (state_q == S_DONE) && (par_err_q || stp_err_q);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with cycle-indexed reference model
module tb_uart_rx_ctrl;
    localparam int DW   = 8;
    localparam int PW   = 6;
    localparam int MAXC = 40000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_in = 1'b1;
    logic          par_en_in = 1'b0;
    logic [PW-1:0] prescale_in = PW'(8);
    logic          strt_glitch_in = 1'b0;
    logic          par_err_in = 1'b0;
    logic          stp_err_in = 1'b0;
    logic [PW-1:0] edge_cnt_out;
    logic [3:0]    bit_cnt_out;
    logic          dat_samp_en_out, strt_chk_en_out, deser_en_out, par_chk_en_out;
    logic          stp_chk_en_out, data_valid_out, frame_err_out;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk(clk), .reset_n(reset_n), .rx_in(rx_in), .par_en_in(par_en_in),
        .prescale_in(prescale_in), .strt_glitch_in(strt_glitch_in),
        .par_err_in(par_err_in), .stp_err_in(stp_err_in),
        .edge_cnt_out(edge_cnt_out), .bit_cnt_out(bit_cnt_out),
        .dat_samp_en_out(dat_samp_en_out), .strt_chk_en_out(strt_chk_en_out),
        .deser_en_out(deser_en_out), .par_chk_en_out(par_chk_en_out),
        .stp_chk_en_out(stp_chk_en_out), .data_valid_out(data_valid_out),
        .frame_err_out(frame_err_out)
    );

    // kinds: 0 strt_chk, 1 deser, 2 par_chk, 3 stp_chk, 4 data_valid, 5 frame_err
    typedef struct {int cyc; int kind;} ev_t;
    ev_t evq[$];

    int cyc = 0;
    bit exp_samp [MAXC];
    int exp_edge [MAXC];
    int exp_bit  [MAXC];
    int n_cmp = 0, n_err = 0;
    int g_gl_cyc = -1, g_par_cyc = -1, g_stp_cyc = -1;
    bit g_gl_val = 0, g_par_val = 0, g_stp_val = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Checker results are meaningful only on the expected strobe cycle; noise elsewhere.
    always @(posedge clk) begin
        #1;
        strt_glitch_in = (cyc == g_gl_cyc)  ? g_gl_val  : 1'($urandom);
        par_err_in     = (cyc == g_par_cyc) ? g_par_val : 1'($urandom);
        stp_err_in     = (cyc == g_stp_cyc) ? g_stp_val : 1'($urandom);
    end

    task automatic check_ev(input logic v, input int k, input int c);
        ev_t e;
        if (v !== 1'b0) begin
            n_cmp++;
            if (evq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cyc=%0d kind=%0d value=%b, none expected", c, k, v);
            end else begin
                e = evq.pop_front();
                if (e.kind != k || e.cyc != c || v !== 1'b1) begin
                    n_err++;
                    $display("FAIL pulse got kind=%0d cyc=%0d value=%b, want kind=%0d cyc=%0d",
                             k, c, v, e.kind, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c < MAXC) begin
            n_cmp++;
            if (dat_samp_en_out !== exp_samp[c] || edge_cnt_out !== PW'(exp_edge[c]) ||
                bit_cnt_out !== 4'(exp_bit[c])) begin
                n_err++;
                $display("FAIL counters cyc=%0d got samp=%b edge=%0d bit=%0d want samp=%0d edge=%0d bit=%0d",
                         c, dat_samp_en_out, edge_cnt_out, bit_cnt_out,
                         exp_samp[c], exp_edge[c], exp_bit[c]);
            end
        end
        check_ev(strt_chk_en_out, 0, c);
        check_ev(deser_en_out,    1, c);
        check_ev(par_chk_en_out,  2, c);
        check_ev(stp_chk_en_out,  3, c);
        check_ev(data_valid_out,  4, c);
        check_ev(frame_err_out,   5, c);
    end

    task automatic check_zero(input string nm);
        n_cmp++;
        if ({edge_cnt_out, bit_cnt_out, dat_samp_en_out, strt_chk_en_out, deser_en_out,
             par_chk_en_out, stp_chk_en_out, data_valid_out, frame_err_out} !== '0) begin
            n_err++;
            $display("FAIL %s outputs edge=%0d bit=%0d strobes=%b%b%b%b%b%b%b, want all 0",
                     nm, edge_cnt_out, bit_cnt_out, dat_samp_en_out, strt_chk_en_out,
                     deser_en_out, par_chk_en_out, stp_chk_en_out, data_valid_out, frame_err_out);
        end
    endtask

    task automatic push_ev(input int c, input int k, input int lim);
        ev_t e;
        if (lim == 0 || c < lim) begin
            e.cyc = c;
            e.kind = k;
            evq.push_back(e);
        end
    endtask

    task automatic run_frame(input logic [7:0] data, input int pre, input bit pen,
                             input bit perr, input bit serr, input bit glitch,
                             input bit chained, input bit next_b2b, input int abort_rel,
                             input int gap);
        int t0, p, chk, s, endc, rel, k, lim;
        if (!chained) begin
            repeat (gap) begin
                @(posedge clk); #1;
                rx_in = 1'b1;
                prescale_in = PW'($urandom);
                par_en_in = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        rx_in = 1'b0;
        prescale_in = PW'(pre);
        par_en_in = pen;
        t0 = cyc;
        p = pre & ~1;
        if (p < 8) p = 8;
        chk = p / 2 + 2;
        s = glitch ? t0 + 1 + chk : t0 + 1 + p * (DW + 1 + int'(pen)) + chk;
        endc = s + 1;
        lim = (abort_rel == 0) ? 0 : t0 + abort_rel;
        for (int c = t0 + 1; c <= s; c++) begin
            if ((lim == 0 || c < lim) && c < MAXC) begin
                exp_samp[c] = 1'b1;
                exp_edge[c] = (c - t0 - 1) % p;
                exp_bit[c]  = (c - t0 - 1) / p;
            end
        end
        push_ev(t0 + 1 + chk, 0, lim);
        g_gl_cyc = t0 + 1 + chk;
        g_gl_val = glitch;
        if (!glitch) begin
            for (int b = 0; b < DW; b++) push_ev(t0 + 1 + p * (b + 1) + chk, 1, lim);
            if (pen) begin
                push_ev(t0 + 1 + p * (DW + 1) + chk, 2, lim);
                g_par_cyc = t0 + 1 + p * (DW + 1) + chk;
                g_par_val = perr;
            end
            push_ev(s, 3, lim);
            g_stp_cyc = s;
            g_stp_val = serr;
            push_ev(s + 1, ((pen && perr) || serr) ? 5 : 4, lim);
        end
        for (int c = t0 + 1; c <= endc; c++) begin
            @(posedge clk); #1;
            if (lim != 0 && c == lim) begin
                reset_n = 1'b0;
                rx_in = 1'b1;
                #1 check_zero("mid_frame_reset");
                repeat (3) begin @(posedge clk); #1; end
                reset_n = 1'b1;
                return;
            end
            rel = c - t0;
            k = rel / p;
            if (glitch)               rx_in = (rel < 2) ? 1'b0 : 1'b1;
            else if (k == 0)          rx_in = 1'b0;
            else if (k <= DW)         rx_in = data[k-1];
            else if (pen && k == DW + 1) rx_in = ^data;
            else                      rx_in = 1'b1;
            prescale_in = PW'($urandom);
            par_en_in = 1'($urandom);
            if (c == endc && !glitch) rx_in = next_b2b ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        bit prev_b2b, gl, nb;
        repeat (3) @(posedge clk);
        #1 check_zero("in_reset");
        reset_n = 1'b1;
        run_frame(8'hA5, 8,  0, 0, 0, 0, 0, 0, 0, 3);
        run_frame(8'h6B, 8,  1, 1, 0, 0, 0, 0, 0, 3);
        run_frame(8'h00, 8,  0, 0, 0, 1, 0, 0, 0, 3);
        run_frame(8'h3C, 16, 0, 0, 1, 0, 0, 0, 0, 4);
        run_frame(8'h81, 8,  0, 0, 0, 0, 0, 1, 0, 3);
        run_frame(8'hC3, 8,  0, 0, 0, 0, 1, 0, 0, 0);
        run_frame(8'h5A, 8,  0, 0, 0, 0, 0, 0, 36, 3);
        run_frame(8'h96, 8,  0, 0, 0, 0, 0, 0, 0, 3);
        run_frame(8'h11, 5,  1, 0, 0, 0, 0, 0, 0, 2);
        run_frame(8'h22, 13, 1, 0, 0, 0, 0, 0, 0, 2);
        prev_b2b = 0;
        for (int i = 0; i < 30; i++) begin
            gl = ($urandom_range(0, 7) == 0);
            nb = (gl || i == 29) ? 1'b0 : 1'($urandom);
            run_frame(8'($urandom), $urandom_range(0, 34), 1'($urandom),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      gl, prev_b2b, nb, 0, $urandom_range(0, 5));
            prev_b2b = nb;
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (evq.size() != 0) begin
            n_err++;
            $display("FAIL missing_pulses outstanding=%0d next_kind=%0d next_cyc=%0d, want 0 outstanding",
                     evq.size(), evq[0].kind, evq[0].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
